// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser
// Purpose  : Turns a UART byte stream of 4-byte records (row, R, G, B) into
//            LED frame-buffer row writes, with frame-complete tracking.
//            Optional inter-byte timeout enabled by macro FRAME_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    output logic       wr_en_o,
    output logic [2:0] wr_row_o,
    output logic [7:0] wr_r_o,
    output logic [7:0] wr_g_o,
    output logic [7:0] wr_b_o,
    output logic       frame_done_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        S_ROW = 2'd0,
        S_R   = 2'd1,
        S_G   = 2'd2,
        S_B   = 2'd3
    } state_t;

    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] row_mask_q, row_mask_d;
    logic [7:0] mask_set;

    logic       wr_en_q, wr_en_d;
    logic [2:0] wr_row_q, wr_row_d;
    logic [7:0] wr_r_q, wr_r_d;
    logic [7:0] wr_g_q, wr_g_d;
    logic [7:0] wr_b_q, wr_b_d;
    logic       frame_done_q, frame_done_d;
    logic       err_q, err_d;
    logic       timeout;

`ifdef FRAME_TIMEOUT_EN
    logic [19:0] idle_q, idle_d;

    // Saturating so a long idle period in S_ROW never wraps the counter.
    always_comb begin
        idle_d = idle_q;
        if (byte_valid_i) begin
            idle_d = 20'd0;
        end else if (idle_q != TIMEOUT_LAST) begin
            idle_d = idle_q + 20'd1;
        end
    end

    // A byte arriving on the timeout cycle takes priority.
    assign timeout = !byte_valid_i && (state_q != S_ROW) && (idle_q == TIMEOUT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_q <= 20'd0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_LAST;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        r_d          = r_q;
        g_d          = g_q;
        row_mask_d   = row_mask_q;
        mask_set     = row_mask_q;
        wr_en_d      = 1'b0;
        wr_row_d     = wr_row_q;
        wr_r_d       = wr_r_q;
        wr_g_d       = wr_g_q;
        wr_b_d       = wr_b_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;

        if (byte_valid_i) begin
            case (state_q)
                S_ROW: begin
                    if (byte_data_i[7:3] == 5'd0) begin
                        row_d   = byte_data_i[2:0];
                        state_d = S_R;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_R: begin
                    r_d     = byte_data_i;
                    state_d = S_G;
                end
                S_G: begin
                    g_d     = byte_data_i;
                    state_d = S_B;
                end
                S_B: begin
                    state_d  = S_ROW;
                    wr_en_d  = 1'b1;
                    wr_row_d = row_q;
                    wr_r_d   = r_q;
                    wr_g_d   = g_q;
                    wr_b_d   = byte_data_i;
                    mask_set = row_mask_q | (8'd1 << row_q);
                    // Completing the frame restarts row tracking from empty.
                    if (mask_set == 8'hFF) begin
                        frame_done_d = 1'b1;
                        row_mask_d   = 8'h00;
                    end else begin
                        row_mask_d   = mask_set;
                    end
                end
                default: state_d = S_ROW;
            endcase
        end else if (timeout) begin
            state_d = S_ROW;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_ROW;
            row_q        <= 3'd0;
            r_q          <= 8'd0;
            g_q          <= 8'd0;
            row_mask_q   <= 8'd0;
            wr_en_q      <= 1'b0;
            wr_row_q     <= 3'd0;
            wr_r_q       <= 8'd0;
            wr_g_q       <= 8'd0;
            wr_b_q       <= 8'd0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            r_q          <= r_d;
            g_q          <= g_d;
            row_mask_q   <= row_mask_d;
            wr_en_q      <= wr_en_d;
            wr_row_q     <= wr_row_d;
            wr_r_q       <= wr_r_d;
            wr_g_q       <= wr_g_d;
            wr_b_q       <= wr_b_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_row_o     = wr_row_q;
    assign wr_r_o       = wr_r_q;
    assign wr_g_o       = wr_g_q;
    assign wr_b_o       = wr_b_q;
    assign frame_done_o = frame_done_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_parser
// Purpose  : Self-checking bench for uart_frame_parser: record-level model
//            compared every cycle plus literal expectations per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

    localparam int T = 100;

    logic       clk;
    logic       rst_n;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_r, wr_g, wr_b;
    logic       frame_done;
    logic       err;

    int errors = 0;
    int checks = 0;

    uart_frame_parser #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .wr_en_o      (wr_en),
        .wr_row_o     (wr_row),
        .wr_r_o       (wr_r),
        .wr_g_o       (wr_g),
        .wr_b_o       (wr_b),
        .frame_done_o (frame_done),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record-level model: bytes of the current record, set of rows seen.
    logic [7:0] rec[$];
    logic [7:0] filled;
    int         idle;
    logic       exp_wr_en, exp_done, exp_err;
    logic [2:0] exp_row;
    logic [7:0] exp_r, exp_g, exp_b;

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] rb;
        if (!rst_n) begin
            rec.delete();
            filled = 8'd0; idle = 0;
            exp_wr_en = 0; exp_done = 0; exp_err = 0;
            exp_row = 0; exp_r = 0; exp_g = 0; exp_b = 0;
        end else begin
            exp_wr_en = 0; exp_done = 0; exp_err = 0;
            if (byte_valid) begin
                idle = 0;
                if (rec.size() == 0 && byte_data > 8'd7) begin
                    exp_err = 1;
                end else begin
                    rec.push_back(byte_data);
                    if (rec.size() == 4) begin
                        rb        = rec[0];
                        exp_wr_en = 1;
                        exp_row   = rb[2:0];
                        exp_r     = rec[1];
                        exp_g     = rec[2];
                        exp_b     = rec[3];
                        filled[rb[2:0]] = 1'b1;
                        if (filled == 8'hFF) begin
                            exp_done = 1;
                            filled   = 8'd0;
                        end
                        rec.delete();
                    end
                end
            end else begin
                if (idle < 1000000) idle++;
`ifdef FRAME_TIMEOUT_EN
                if (rec.size() > 0 && idle >= T) begin
                    rec.delete();
                    exp_err = 1;
                end
`endif
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        checks++;
        if ({wr_en, wr_row, wr_r, wr_g, wr_b, frame_done, err} !==
            {exp_wr_en, exp_row, exp_r, exp_g, exp_b, exp_done, exp_err}) begin
            errors++;
            $display("FAIL cycle_model t=%0t: got en=%b row=%0d r=%h g=%h b=%h done=%b err=%b, expected en=%b row=%0d r=%h g=%h b=%h done=%b err=%b",
                     $time, wr_en, wr_row, wr_r, wr_g, wr_b, frame_done, err,
                     exp_wr_en, exp_row, exp_r, exp_g, exp_b, exp_done, exp_err);
        end
    end

    // Event monitor feeding the literal scenario checks.
    int cyc = 0;
    int wr_cnt, done_cnt, err_cnt, strobe_cyc, wr_cyc, done_row;
    int last_row, last_r, last_g, last_b;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (byte_valid) strobe_cyc = cyc;
        if (wr_en) begin
            wr_cnt++;
            wr_cyc   = cyc;
            last_row = int'(wr_row);
            last_r   = int'(wr_r);
            last_g   = int'(wr_g);
            last_b   = int'(wr_b);
        end
        if (frame_done) begin
            done_cnt++;
            done_row = int'(wr_row);
        end
        if (err) err_cnt++;
    end

    task automatic clear_mon();
        wr_cnt = 0; done_cnt = 0; err_cnt = 0;
        strobe_cyc = 0; wr_cyc = 0; done_row = -1;
        last_row = -1; last_r = -1; last_g = -1; last_b = -1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_write(input string name, input int row, input int r, input int g, input int b);
        chk({name, "_wr_cnt"}, wr_cnt, 1);
        chk({name, "_row"}, last_row, row);
        chk({name, "_r"}, last_r, r);
        chk({name, "_g"}, last_g, g);
        chk({name, "_b"}, last_b, b);
    endtask

    logic [7:0] tx_q[$];

    // gap=0 sends back-to-back; gap=N leaves N idle cycles between bytes.
    task automatic flush(input int gap);
        while (tx_q.size() > 0) begin
            @(posedge clk); #1;
            byte_valid = 1'b1;
            byte_data  = tx_q.pop_front();
            if (gap > 0) begin
                @(posedge clk); #1;
                byte_valid = 1'b0;
                repeat (gap - 1) @(posedge clk);
            end
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
        clear_mon();
        wait_cyc(3);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_wr_b", int'(wr_b), 0);
        rst_n = 1'b1;

        // Single record after reset, latency of one cycle.
        clear_mon();
        tx_q = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        flush(1); wait_cyc(3);
        chk_write("rec0", 0, 255, 0, 255);
        chk("rec0_latency", wr_cyc - strobe_cyc, 1);
        chk("rec0_done", done_cnt, 0);

        // Full frame rows 0..7.
        clear_mon();
        for (int r = 0; r < 8; r++) begin
            tx_q.push_back(8'(r)); tx_q.push_back(8'hFF);
            tx_q.push_back(8'h00); tx_q.push_back(8'hFF);
        end
        flush(1); wait_cyc(3);
        chk("frame_wr_cnt", wr_cnt, 8);
        chk("frame_done_cnt", done_cnt, 1);
        chk("frame_done_row", done_row, 7);

        // Bad row byte then a good record.
        clear_mon();
        tx_q = '{8'h09, 8'h04, 8'h11, 8'h22, 8'h33};
        flush(1); wait_cyc(3);
        chk("badrow_err", err_cnt, 1);
        chk_write("badrow", 4, 8'h11, 8'h22, 8'h33);

`ifdef FRAME_TIMEOUT_EN
        clear_mon();
        tx_q = '{8'h03, 8'hAA};
        flush(1); wait_cyc(105);
        chk("timeout_err", err_cnt, 1);
        chk("timeout_no_wr", wr_cnt, 0);
        tx_q = '{8'h05, 8'h11, 8'h22, 8'h33};
        flush(1); wait_cyc(3);
        chk_write("after_to", 5, 8'h11, 8'h22, 8'h33);
        // Bytes landing around the timeout boundary.
        for (int d = 96; d <= 101; d++) begin
            tx_q = '{8'h07};
            flush(1); wait_cyc(d);
            tx_q = '{8'h01, 8'h02, 8'h03};
            flush(1); wait_cyc(110);
        end
`else
        clear_mon();
        tx_q = '{8'h03, 8'hAA};
        flush(1); wait_cyc(120);
        chk("notimeout_err", err_cnt, 0);
        chk("notimeout_no_wr", wr_cnt, 0);
        tx_q = '{8'h44, 8'h55};
        flush(1); wait_cyc(3);
        chk_write("slow_rec", 3, 8'hAA, 8'h44, 8'h55);
`endif

        // Reset in the middle of a record.
        clear_mon();
        tx_q = '{8'h02, 8'h44};
        flush(1);
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        chk("midrst_no_wr", wr_cnt, 0);
        chk("midrst_no_err", err_cnt, 0);
        tx_q = '{8'h02, 8'h01, 8'h02, 8'h03};
        flush(1); wait_cyc(3);
        chk_write("midrst", 2, 1, 2, 3);

        // Back-to-back rows 0..6, a repeated 0, then 7.
        clear_mon();
        for (int r = 0; r < 9; r++) begin
            tx_q.push_back(r < 7 ? 8'(r) : (r == 7 ? 8'd0 : 8'd7));
            tx_q.push_back(8'(8'h10 + r));
            tx_q.push_back(8'(8'h20 + r));
            tx_q.push_back(8'(8'h30 + r));
        end
        flush(0); wait_cyc(3);
        chk("b2b_wr_cnt", wr_cnt, 9);
        chk("b2b_done_cnt", done_cnt, 1);
        chk("b2b_done_row", done_row, 7);
        chk("b2b_last_b", last_b, 8'h38);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
